// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - UART boot loader: length-prefixed word stream into instruction memory.
// Optional trailing checksum byte is built when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_loader #(
  parameter int          ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {LEN, DATA, CSUM, FLUSH, DONE, ERR} state_t;

  localparam logic [32:0] MAX_N = 33'(MAX_WORDS);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       sr;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] n_last;
  logic [31:0]       rx_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // The three earlier bytes of a field sit in sr; the current byte completes it.
  assign rx_word = {sr, rx_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= LEN;
      byte_cnt   <= 2'd0;
      sr         <= 24'd0;
      word_idx   <= '0;
      n_last     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      busy       <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        state     <= LEN;
        byte_cnt  <= 2'd0;
        sr        <= 24'd0;
        word_idx  <= '0;
        n_last    <= '0;
        imem_addr <= '0;
        busy      <= 1'b1;
        boot_done <= 1'b0;
        boot_err  <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum      <= 8'd0;
`endif
      end else if (rx_ferr && (state == LEN || state == DATA || state == CSUM)) begin
        state    <= ERR;
        busy     <= 1'b0;
        boot_err <= 1'b1;
      end else begin
        case (state)
          LEN: begin
            if (rx_valid) begin
              byte_cnt <= byte_cnt + 2'd1;
              sr       <= rx_word[23:0];
              if (byte_cnt == 2'd3) begin
                if (rx_word == 32'd0) begin
                  state <= FLUSH;
                end else if ({1'b0, rx_word} > MAX_N) begin
                  state    <= ERR;
                  busy     <= 1'b0;
                  boot_err <= 1'b1;
                end else begin
                  n_last   <= ADDR_W'(rx_word - 32'd1);
                  word_idx <= '0;
                  state    <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              byte_cnt <= byte_cnt + 2'd1;
              sr       <= rx_word[23:0];
`ifdef BOOT_LOADER_CHECKSUM_EN
              csum     <= csum + rx_data;
`endif
              if (byte_cnt == 2'd3) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= rx_word;
                if (word_idx == n_last) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                  state <= CSUM;
`else
                  state <= FLUSH;
`endif
                end else begin
                  word_idx <= word_idx + ADDR_W'(1);
                end
              end
            end
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          CSUM: begin
            if (rx_valid) begin
              if (rx_data == csum) begin
                state <= FLUSH;
              end else begin
                state    <= ERR;
                busy     <= 1'b0;
                boot_err <= 1'b1;
              end
            end
          end
`endif
          // One idle cycle so the last write retires before the core leaves reset.
          FLUSH: begin
            state     <= DONE;
            busy      <= 1'b0;
            boot_done <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader.
module tb_boot_loader;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rstn;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              boot_done;
  logic              boot_err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int base;
  logic [ADDR_W-1:0] q_addr[$];
  logic [31:0]       q_data[$];

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ferr(rx_ferr), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt <= we_cnt + 1;
      q_addr.push_back(imem_addr);
      q_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; rx_ferr = 1'b0; reload = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(boot_done), 32'd0);
    check("rst_err", 32'(boot_err), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // two-word program
    base = we_cnt;
    send_word(32'h0000_0002);
    send_word(32'h2001_0005);
    send_word(32'h0000_0000);
    check("p2_last_we", 32'(imem_we), 32'd1);
    check("p2_last_addr", 32'(imem_addr), 32'd1);
    check("p2_last_data", imem_wdata, 32'h0000_0000);
    check("p2_flush_done", 32'(boot_done), 32'd0);
    check("p2_flush_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("p2_done", 32'(boot_done), 32'd1);
    check("p2_done_busy", 32'(busy), 32'd0);
    check("p2_done_we", 32'(imem_we), 32'd0);
    send(8'hFF);
    @(negedge clk);
    check("p2_wcount", 32'(we_cnt - base), 32'd2);
    check("p2_addr0", 32'(q_addr[base]), 32'd0);
    check("p2_data0", q_data[base], 32'h2001_0005);
    check("p2_addr1", 32'(q_addr[base+1]), 32'd1);
    check("p2_hold_done", 32'(boot_done), 32'd1);

    // empty program
    do_reload();
    check("rl_busy", 32'(busy), 32'd1);
    check("rl_done", 32'(boot_done), 32'd0);
    base = we_cnt;
    send_word(32'h0000_0000);
    check("p0_flush_busy", 32'(busy), 32'd1);
    check("p0_flush_done", 32'(boot_done), 32'd0);
    @(negedge clk);
    check("p0_done", 32'(boot_done), 32'd1);
    @(negedge clk);
    check("p0_wcount", 32'(we_cnt - base), 32'd0);

    // over-long program
    do_reload();
    base = we_cnt;
    send_word(32'h0000_8001);
    check("big_err", 32'(boot_err), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    send_word(32'h1234_5678);
    @(negedge clk);
    check("big_err_hold", 32'(boot_err), 32'd1);
    check("big_done", 32'(boot_done), 32'd0);
    check("big_wcount", 32'(we_cnt - base), 32'd0);

    // largest legal length is accepted
    do_reload();
    send_word(32'h0000_8000);
    check("max_err", 32'(boot_err), 32'd0);
    check("max_busy", 32'(busy), 32'd1);

    // framing error on byte 2 of word 1, together with rx_valid
    do_reload();
    base = we_cnt;
    send_word(32'h0000_0002);
    send_word(32'hA1A2_A3A4);
    send(8'hB1);
    rx_data = 8'hB2; rx_valid = 1'b1; rx_ferr = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_ferr = 1'b0;
    check("ferr_err", 32'(boot_err), 32'd1);
    check("ferr_busy", 32'(busy), 32'd0);
    send(8'hB3);
    send(8'hB4);
    @(negedge clk);
    check("ferr_wcount", 32'(we_cnt - base), 32'd1);
    check("ferr_addr0", 32'(q_addr[base]), 32'd0);
    check("ferr_data0", q_data[base], 32'hA1A2_A3A4);
    do_reload();
    check("ferr_rl_busy", 32'(busy), 32'd1);
    check("ferr_rl_err", 32'(boot_err), 32'd0);

    // framing error with the length counter at 0
    rx_ferr = 1'b1;
    @(negedge clk);
    rx_ferr = 1'b0;
    check("ferr_len0", 32'(boot_err), 32'd1);

    // reload wins over a simultaneous framing error
    reload = 1'b1; rx_ferr = 1'b1;
    @(negedge clk);
    reload = 1'b0; rx_ferr = 1'b0;
    check("rl_vs_ferr", 32'(boot_err), 32'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_reload();
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    send(8'h0A);
    @(negedge clk);
    check("cs_ok_done", 32'(boot_done), 32'd1);
    check("cs_ok_err", 32'(boot_err), 32'd0);
    do_reload();
    base = we_cnt;
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    send(8'h0B);
    @(negedge clk);
    check("cs_bad_err", 32'(boot_err), 32'd1);
    check("cs_bad_done", 32'(boot_done), 32'd0);
    check("cs_bad_wcount", 32'(we_cnt - base), 32'd1);
    check("cs_bad_addr", 32'(q_addr[base]), 32'd0);
`endif

    // reset in the middle of a word
    do_reload();
    base = we_cnt;
    send_word(32'h0000_0001);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    rstn = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd1);
    check("mr_err", 32'(boot_err), 32'd0);
    check("mr_we", 32'(imem_we), 32'd0);
    check("mr_addr", 32'(imem_addr), 32'd0);
    check("mr_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    send_word(32'h0000_0001);
    send_word(32'h1122_3344);
    check("mr_new_we", 32'(imem_we), 32'd1);
    check("mr_new_addr", 32'(imem_addr), 32'd0);
    check("mr_new_data", imem_wdata, 32'h1122_3344);
`ifndef BOOT_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("mr_new_done", 32'(boot_done), 32'd1);
`endif
    @(negedge clk);
    check("mr_wcount", 32'(we_cnt - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
